fifo_async: RTL and testbench
=============================

FIFO_ASYNC -- requirements
Module: fifo_async

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the width of each data word in bits.
REQ-002 Parameter DEPTH, default 16, sets the number of entries; it SHALL be a power of 2 and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port wr_en, input, 1 bit: write request.
REQ-006 Port rd_en, input, 1 bit: read request.
REQ-007 Port data_in, input, DATA_WIDTH bits: write data.
REQ-008 Port data_out, output, DATA_WIDTH bits: registered read data.
REQ-009 Port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-010 Port empty, output, 1 bit: FIFO holds 0 entries.

Function
REQ-011 Storage SHALL be DEPTH x DATA_WIDTH, with write and read pointers each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
REQ-012 empty SHALL be 1 when wr_ptr equals rd_ptr.
REQ-013 full SHALL be 1 when the pointer index bits are equal and the wrap bits differ.
REQ-014 Both flags SHALL be combinational decodes of the registered pointers, so they are valid in the same cycle as the edge that changes the pointers.
REQ-015 A write SHALL be accepted when wr_en=1 and (full=0, or full=1 with an accepted read in the same cycle); an accepted write stores data_in at wr_ptr and increments wr_ptr modulo 2*DEPTH.
REQ-016 A read SHALL be accepted when rd_en=1 and empty=0; an accepted read loads mem[rd_ptr] into data_out on that edge (1-cycle latency) and increments rd_ptr modulo 2*DEPTH.
REQ-017 data_out SHALL hold its previous value in any cycle without an accepted read.
REQ-018 A write when full without a simultaneous read SHALL be dropped, with no change to memory, pointers or flags.
REQ-019 A read when empty SHALL be ignored, with data_out and the pointers unchanged.
REQ-020 When simultaneous wr_en and rd_en occur while empty, only the write SHALL be accepted; there is no write-to-read bypass.
REQ-021 Simultaneous accepted read and write SHALL leave the occupancy unchanged.
REQ-022 Pointer wrap-around SHALL be seamless, preserving FIFO order across any number of wraps.

Reset
REQ-023 While rst_n=0, regardless of clk: wr_ptr=0, rd_ptr=0, data_out=0, empty=1, full=0.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries immediately.
REQ-026 The first accepted write SHALL be on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 Macro FIFO_ASYNC_ERR_FLAGS_EN, when defined, SHALL add two sticky 1-bit outputs: overflow, set by a dropped write (REQ-018), and underflow, set by an ignored read (REQ-019).
REQ-028 With FIFO_ASYNC_ERR_FLAGS_EN defined, overflow and underflow SHALL be cleared only by rst_n=0 and reset to 0.
REQ-029 Without FIFO_ASYNC_ERR_FLAGS_EN defined, the overflow and underflow ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Reset scenario: hold rst_n=0 for 2 cycles -> empty=1, full=0, data_out=0; assert rst_n low between clock edges -> outputs clear immediately.
REQ-031 Fill scenario: 16 writes of 0x01..0x10 -> full=1 after the 16th edge, empty=0; a 17th write of 0xFF is dropped (overflow=1 when FIFO_ASYNC_ERR_FLAGS_EN is defined).
REQ-032 Drain scenario: 16 reads -> data_out = 0x01..0x10 in order, each on the edge of its read; empty=1 after the 16th; an 18th read leaves data_out=0x10 (underflow=1 when enabled).
REQ-033 Simultaneous scenario: with 8 entries stored, 20 cycles of wr_en=rd_en=1 with an incrementing data pattern -> occupancy stays 8, order is preserved across pointer wrap, and full and empty both stay 0.
REQ-034 Boundary scenario: when full, wr_en=rd_en=1 -> both accepted, full stays 1; when empty, wr_en=rd_en=1 with data_in 0xA5 -> data_out unchanged, empty=0 next cycle, next read returns 0xA5.

Source files
------------

// File: rtl/fifo_async.sv
// Single-clock FIFO with registered read data and wrap-bit pointers.
// Define FIFO_ASYNC_ERR_FLAGS_EN to add the sticky overflow/underflow outputs.
module fifo_async #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
`else
    output logic                  empty
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_accept;
    logic                  rd_accept;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A read frees a slot on the same edge, so a write into a full FIFO may proceed with it.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            data_out_d = mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    assign data_out = data_out_q;

`ifdef FIFO_ASYNC_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && !wr_accept) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_async.sv
// Directed self-checking bench for fifo_async (DATA_WIDTH=8, DEPTH=16).
// Honours FIFO_ASYNC_ERR_FLAGS_EN for the optional error flag checks.
module tb_fifo_async;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int total;
    int bad;

    fifo_async #(
        .DATA_WIDTH(8),
        .DEPTH     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
        .empty    (empty),
        .overflow (overflow),
        .underflow(underflow)
`else
        .empty    (empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given request; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;

        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_dout", 32'(data_out), 32'h00);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            if (i == 1) check_eq("fill_first_empty", 32'(empty), 32'd0);
            if (i == 15) check_eq("fill_15_full", 32'(full), 32'd0);
        end
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_empty", 32'(empty), 32'd0);
        cyc(1'b1, 1'b0, 8'hFF);
        check_eq("drop_full", 32'(full), 32'd1);
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
        check_eq("overflow_set", 32'(overflow), 32'd1);
        check_eq("underflow_clr", 32'(underflow), 32'd0);
`endif

        // Drain; the dropped 0xFF must not appear
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check_eq($sformatf("drain_%0d", i), 32'(data_out), 32'(i));
        end
        check_eq("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        check_eq("underrun_dout", 32'(data_out), 32'h10);
        check_eq("underrun_empty", 32'(empty), 32'd1);
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
        check_eq("underflow_set", 32'(underflow), 32'd1);
        check_eq("overflow_sticky", 32'(overflow), 32'd1);
`endif

        // Simultaneous read/write with 8 stored, across pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b1, 8'(8'h28 + k));
            check_eq($sformatf("sim_dout_%0d", k), 32'(data_out), 32'(8'h20 + k));
            check_eq($sformatf("sim_flags_%0d", k), {30'd0, full, empty}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check_eq($sformatf("sim_drain_%0d", i), 32'(data_out), 32'(8'h34 + i));
        end
        check_eq("sim_drain_empty", 32'(empty), 32'd1);

        // Full boundary: simultaneous request accepted on both sides
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
        check_eq("bnd_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 8'h99);
        check_eq("bnd_full_dout", 32'(data_out), 32'h40);
        check_eq("bnd_full_stays", 32'(full), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            if (i < 16) check_eq($sformatf("bnd_drain_%0d", i), 32'(data_out), 32'(8'h40 + i));
            else check_eq("bnd_drain_last", 32'(data_out), 32'h99);
        end
        check_eq("bnd_drain_empty", 32'(empty), 32'd1);

        // Empty boundary: no bypass, only the write lands
        cyc(1'b1, 1'b1, 8'hA5);
        check_eq("bnd_empty_dout", 32'(data_out), 32'h99);
        check_eq("bnd_empty_notempty", 32'(empty), 32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        check_eq("bnd_empty_read", 32'(data_out), 32'hA5);
        check_eq("bnd_empty_after", 32'(empty), 32'd1);

        // Reset asserted between edges mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_empty", 32'(empty), 32'd1);
        check_eq("async_rst_full", 32'(full), 32'd0);
        check_eq("async_rst_dout", 32'(data_out), 32'h00);
`ifdef FIFO_ASYNC_ERR_FLAGS_EN
        check_eq("async_rst_ovf", 32'(overflow), 32'd0);
        check_eq("async_rst_unf", 32'(underflow), 32'd0);
`endif
        #2 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h5A);
        check_eq("post_rst_write", 32'(empty), 32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        check_eq("post_rst_read", 32'(data_out), 32'h5A);
        check_eq("post_rst_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
